// File: rtl/alu_seq_divider.sv
// Sequential unsigned divider that drives the shared execute-stage ALU.
// One restoring-division step per cycle: the ALU subtractor produces the
// trial difference, and an unsigned compare decides whether to keep it.
//
// Handshake: start is only sampled in IDLE, and nothing is queued. busy is
// high in CHECK and ITER. done pulses for one cycle with valid results.
// quotient, remainder and div_by_zero then hold until the next DONE.
module alu_seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_ITER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Current FSM state; checkers can bind to this signal directly.
   state_t           state;
   logic [WIDTH-1:0] q_r;   // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] d_r;   // latched divisor
   logic [WIDTH-1:0] r_r;   // partial remainder
   logic [CNT_W-1:0] cnt;   // remaining iteration steps

   logic [WIDTH:0]   t;
   logic             ge;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   // One restoring step. T[WIDTH] set means T already exceeds any divisor.
   // The compare is unsigned on purpose; ALU SLT would treat D as signed.
   always_comb begin
      t      = {r_r, q_r[WIDTH-1]};
      ge     = t[WIDTH] | (t[WIDTH-1:0] >= d_r);
      q_next = {q_r[WIDTH-2:0], ge};
      r_next = ge ? alu_out : t[WIDTH-1:0];
   end

   // ALU operand and operation select, decoded from state registers only.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = ALU_ADD;
      case (state)
         S_CHECK: begin
            alu_a    = d_r;
            alu_b    = '0;
            alu_ctrl = ALU_OR;
         end
         S_ITER: begin
            alu_a    = t[WIDTH-1:0];
            alu_b    = d_r;
            alu_ctrl = ALU_SUB;
         end
         default: begin
            alu_a    = '0;
            alu_b    = '0;
            alu_ctrl = ALU_ADD;
         end
      endcase
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         q_r         <= '0;
         d_r         <= '0;
         r_r         <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  q_r   <= dividend;
                  d_r   <= divisor;
                  r_r   <= '0;
                  busy  <= 1'b1;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               // D OR 0 through the ALU: the zero flag says the divisor is 0.
               if (alu_zero) begin
                  quotient    <= '1;
                  remainder   <= q_r;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_DONE;
               end else begin
                  cnt   <= CNT_W'(WIDTH);
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               r_r <= r_next;
               q_r <= q_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               // start is ignored here; it is taken in the following IDLE.
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed bench for alu_seq_divider. The ALU is modelled here as a
// combinational block. Vectors come from a table of hand-computed results,
// and hand-written sequences cover ignored starts and reset during an operation.
module tb_alu_seq_divider;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_out;
   logic         alu_zero;

   int n_vec = 0;
   int n_err = 0;

   alu_seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference combinational ALU.
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0010: alu_out = alu_a + alu_b;
         4'b0110: alu_out = alu_a - alu_b;
         4'b0111: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         default: alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_dz;
      int           exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one division and follow it to the done pulse. On return the
   // current time is the negedge inside the DONE cycle. When inject is set,
   // competing starts are pulsed in cycles 5 and 20 and must be ignored.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                         output int lat, output bit seq_ok);
      int cyc;
      seq_ok = 1'b1;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      cyc      = 1;
      while (!done && cyc < 100) begin
         if (busy !== 1'b1) seq_ok = 1'b0;
         if (cyc == 1) begin
            if (alu_ctrl !== 4'b0001 || alu_a !== b || alu_b !== '0) seq_ok = 1'b0;
         end else begin
            if (alu_ctrl !== 4'b0110 || alu_b !== b) seq_ok = 1'b0;
         end
         if (inject && (cyc == 5 || cyc == 20)) begin
            start    = 1'b1;
            dividend = 32'd50 + W'(cyc);
            divisor  = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!done) begin
         seq_ok = 1'b0;
         $display("FAIL timeout: no done for %h/%h", a, b);
      end
      if (busy !== 1'b0 || alu_ctrl !== 4'b0010 || alu_a !== '0) seq_ok = 1'b0;
      lat = cyc;
   endtask

   initial begin
      int lat;
      bit ok;
      bit hold_ok;
      logic [W-1:0] q_s;
      logic [W-1:0] r_s;
      logic         dz_s;

      vecs[0] = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 34};
      vecs[1] = '{32'd5,        32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
      vecs[2] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1,          32'h7FFF_FFFE,  1'b0, 34};
      vecs[3] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,  32'd0,          1'b0, 34};
      vecs[4] = '{32'd3,        32'd10,         32'd0,          32'd3,          1'b0, 34};
      vecs[5] = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, 34};
      vecs[6] = '{32'h1234_5678, 32'd1000,      32'd305419,     32'd896,        1'b0, 34};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'd1,          32'd0,          1'b0, 34};

      // Reset.
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", W'(busy), '0);
      chk("reset done", W'(done), '0);
      chk("reset quotient", quotient, '0);
      chk("reset remainder", remainder, '0);
      chk("reset dz", W'(div_by_zero), '0);
      chk("reset alu_ctrl", W'(alu_ctrl), 32'd2);
      chk("reset alu_a", alu_a, '0);
      rst_n = 1'b1;

      // Table-driven vectors, each followed by a five-cycle hold check.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, lat, ok);
         chk($sformatf("v%0d quotient", i), quotient, vecs[i].exp_q);
         chk($sformatf("v%0d remainder", i), remainder, vecs[i].exp_r);
         chk($sformatf("v%0d dz", i), W'(div_by_zero), W'(vecs[i].exp_dz));
         chk($sformatf("v%0d latency", i), W'(lat), W'(vecs[i].exp_lat));
         chk($sformatf("v%0d sequence", i), W'(ok), 32'd1);
         q_s     = quotient;
         r_s     = remainder;
         dz_s    = div_by_zero;
         hold_ok = 1'b1;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== q_s ||
                remainder !== r_s || div_by_zero !== dz_s) hold_ok = 1'b0;
         end
         chk($sformatf("v%0d hold", i), W'(hold_ok), 32'd1);
      end

      // Starts during an operation are ignored.
      run_op(32'd100, 32'd7, 1'b1, lat, ok);
      chk("inject quotient", quotient, 32'd14);
      chk("inject remainder", remainder, 32'd2);
      chk("inject latency", W'(lat), 32'd34);
      chk("inject sequence", W'(ok), 32'd1);

      // Back-to-back: start in the IDLE cycle right after DONE.
      run_op(32'd9, 32'd2, 1'b0, lat, ok);
      chk("b2b quotient", quotient, 32'd4);
      chk("b2b remainder", remainder, 32'd1);
      chk("b2b latency", W'(lat), 32'd34);

      // Reset in cycle 10 of an operation discards it.
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst busy", W'(busy), '0);
      chk("midrst done", W'(done), '0);
      chk("midrst quotient", quotient, '0);
      chk("midrst remainder", remainder, '0);
      chk("midrst alu_ctrl", W'(alu_ctrl), 32'd2);
      run_op(32'd9, 32'd3, 1'b0, lat, ok);
      chk("post-rst quotient", quotient, 32'd3);
      chk("post-rst remainder", remainder, 32'd0);
      chk("post-rst latency", W'(lat), 32'd34);
      chk("post-rst sequence", W'(ok), 32'd1);
      @(negedge clk);
      chk("done pulse width", W'(done), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
